rn_axi_noc_bridge: RTL and testbench

Parametrised request-node bridge between one AXI4 master (CPU side, `s_*`) and the NoC request/response ports (flit side). It does four things:
- Decodes the target node from the address.
- Tracks each accepted AW burst in a write-track FIFO, so W flits carry the correct target and head/tail marks.
- Bounds outstanding writes and reads with counters.
- Unpacks B and R flits back to AXI.

It replaces the fixed 64-bit, 2-bit-target request-node wrapper and adds flow control, burst sequencing and error flags.

---
 rtl/rn_axi_noc_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_rn_axi_noc_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rn_axi_noc_bridge.sv
// Request-node bridge: one AXI4 master onto the NoC request/response flit ports.
// AW/AR are forwarded with a target decoded from the address. A write-track FIFO
// holds {tgt, len} per accepted AW so W flits get their target and head/tail marks.
// Outstanding writes and reads are bounded by counters; B and R are unpacked to AXI.
// Optional: define RN_WLAST_CHECK_EN to flag s_w_last disagreeing with the computed tail.
module rn_axi_noc_bridge #(
    parameter int unsigned ID_W     = 11,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned TGT_W    = 2,
    parameter int unsigned TGT_LSB  = 30,
    parameter int unsigned WQ_DEPTH = 4,
    parameter int unsigned MAX_WR   = 8,
    parameter int unsigned MAX_RD   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // AXI AW
    input  logic                         s_aw_valid,
    output logic                         s_aw_ready,
    input  logic [ID_W-1:0]              s_aw_id,
    input  logic [ADDR_W-1:0]            s_aw_addr,
    input  logic [7:0]                   s_aw_len,
    // AXI W
    input  logic                         s_w_valid,
    output logic                         s_w_ready,
    input  logic [DATA_W-1:0]            s_w_data,
    input  logic [DATA_W/8-1:0]          s_w_strb,
    input  logic                         s_w_last,
    // AXI B
    output logic                         s_b_valid,
    input  logic                         s_b_ready,
    output logic [ID_W-1:0]              s_b_id,
    output logic [1:0]                   s_b_resp,
    // AXI AR
    input  logic                         s_ar_valid,
    output logic                         s_ar_ready,
    input  logic [ID_W-1:0]              s_ar_id,
    input  logic [ADDR_W-1:0]            s_ar_addr,
    input  logic [7:0]                   s_ar_len,
    // AXI R
    output logic                         s_r_valid,
    input  logic                         s_r_ready,
    output logic [ID_W-1:0]              s_r_id,
    output logic [DATA_W-1:0]            s_r_data,
    output logic [1:0]                   s_r_resp,
    output logic                         s_r_last,
    // NoC AW
    output logic                         aw_valid,
    input  logic                         aw_ready,
    output logic [ID_W+ADDR_W+8-1:0]     aw_payload,
    output logic [TGT_W-1:0]             aw_tgtid,
    // NoC W
    output logic                         w_valid,
    input  logic                         w_ready,
    output logic                         w_head,
    output logic                         w_tail,
    output logic [DATA_W+DATA_W/8-1:0]   w_payload,
    output logic [TGT_W-1:0]             w_tgtid,
    // NoC B
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [ID_W+2-1:0]            b_payload,
    // NoC AR
    output logic                         ar_valid,
    input  logic                         ar_ready,
    output logic [ID_W+ADDR_W+8-1:0]     ar_payload,
    output logic [TGT_W-1:0]             ar_tgtid,
    // NoC R
    input  logic                         r_valid,
    output logic                         r_ready,
    input  logic                         r_head,
    input  logic                         r_tail,
    input  logic [ID_W+DATA_W+2-1:0]     r_payload,
    // Sticky error flags
    output logic                         err_wlast,
    output logic                         err_bunexp
);

    localparam int unsigned PtrW    = $clog2(WQ_DEPTH);
    localparam int unsigned WrCntW  = $clog2(MAX_WR + 1);
    localparam int unsigned RdCntW  = $clog2(MAX_RD + 1);
    localparam logic [WrCntW-1:0] WrLimit = WrCntW'(MAX_WR);
    localparam logic [RdCntW-1:0] RdLimit = RdCntW'(MAX_RD);
    localparam logic [PtrW:0]     PtrOne  = (PtrW + 1)'(1);

    // Write-track FIFO: one {tgt, len} entry per accepted AW burst.
    logic [TGT_W-1:0] wq_tgt_q [WQ_DEPTH];
    logic [7:0]       wq_len_q [WQ_DEPTH];
    logic [PtrW:0]    wq_wptr_q, wq_wptr_d;
    logic [PtrW:0]    wq_rptr_q, wq_rptr_d;
    logic             wq_empty, wq_full;
    logic [TGT_W-1:0] head_tgt;
    logic [7:0]       head_len;

    logic [7:0]        bcnt_q, bcnt_d;
    logic [WrCntW-1:0] wr_cnt_q, wr_cnt_d;
    logic [RdCntW-1:0] rd_cnt_q, rd_cnt_d;
    logic              err_bunexp_q, err_bunexp_d;

    logic aw_en, ar_en;
    logic aw_hs, w_hs, b_hs, ar_hs, r_tail_hs;

    // R head marks carry no information on the AXI side.
    logic unused_r_head;
    assign unused_r_head = r_head;

    assign wq_empty = (wq_wptr_q == wq_rptr_q);
    assign wq_full  = (wq_wptr_q[PtrW] != wq_rptr_q[PtrW]) &&
                      (wq_wptr_q[PtrW-1:0] == wq_rptr_q[PtrW-1:0]);
    assign head_tgt = wq_tgt_q[wq_rptr_q[PtrW-1:0]];
    assign head_len = wq_len_q[wq_rptr_q[PtrW-1:0]];

    // Request-side flow control and handshake gating; everything drops during reset.
    always_comb begin
        aw_en      = !wq_full && (wr_cnt_q < WrLimit);
        ar_en      = (rd_cnt_q < RdLimit);

        aw_valid   = rst_n & s_aw_valid & aw_en;
        s_aw_ready = rst_n & aw_ready & aw_en;
        aw_payload = {s_aw_id, s_aw_addr, s_aw_len};
        aw_tgtid   = s_aw_addr[TGT_LSB +: TGT_W];

        // W waits for its burst to be visible at the FIFO head (write latency 1).
        w_valid    = rst_n & s_w_valid & !wq_empty;
        s_w_ready  = rst_n & w_ready & !wq_empty;
        w_head     = (bcnt_q == 8'd0);
        w_tail     = (bcnt_q == head_len);
        w_payload  = {s_w_data, s_w_strb};
        w_tgtid    = head_tgt;

        s_b_valid  = rst_n & b_valid;
        b_ready    = rst_n & s_b_ready;
        s_b_id     = b_payload[ID_W+1:2];
        s_b_resp   = b_payload[1:0];

        ar_valid   = rst_n & s_ar_valid & ar_en;
        s_ar_ready = rst_n & ar_ready & ar_en;
        ar_payload = {s_ar_id, s_ar_addr, s_ar_len};
        ar_tgtid   = s_ar_addr[TGT_LSB +: TGT_W];

        s_r_valid  = rst_n & r_valid;
        r_ready    = rst_n & s_r_ready;
        s_r_id     = r_payload[ID_W+DATA_W+1:DATA_W+2];
        s_r_data   = r_payload[DATA_W+1:2];
        s_r_resp   = r_payload[1:0];
        s_r_last   = r_tail;

        aw_hs      = aw_valid & aw_ready;
        w_hs       = w_valid & w_ready;
        b_hs       = b_valid & b_ready;
        ar_hs      = ar_valid & ar_ready;
        r_tail_hs  = r_valid & r_ready & r_tail;
    end

    // Next state for FIFO pointers, burst beat counter and outstanding counters.
    always_comb begin
        wq_wptr_d    = aw_hs ? wq_wptr_q + PtrOne : wq_wptr_q;
        wq_rptr_d    = (w_hs && w_tail) ? wq_rptr_q + PtrOne : wq_rptr_q;

        bcnt_d = bcnt_q;
        if (w_hs) begin
            bcnt_d = w_tail ? 8'd0 : bcnt_q + 8'd1;
        end

        // A B with nothing outstanding is flagged; the count never goes below 0.
        err_bunexp_d = err_bunexp_q;
        if (b_hs && (wr_cnt_q == '0)) begin
            err_bunexp_d = 1'b1;
        end
        wr_cnt_d = wr_cnt_q;
        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + WrCntW'(1);
        end else if (b_hs && !aw_hs && (wr_cnt_q != '0)) begin
            wr_cnt_d = wr_cnt_q - WrCntW'(1);
        end

        rd_cnt_d = rd_cnt_q;
        if (ar_hs && !r_tail_hs) begin
            rd_cnt_d = rd_cnt_q + RdCntW'(1);
        end else if (r_tail_hs && !ar_hs && (rd_cnt_q != '0)) begin
            rd_cnt_d = rd_cnt_q - RdCntW'(1);
        end
    end

    // Control state with synchronous reset; reset discards all burst tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wq_wptr_q    <= '0;
            wq_rptr_q    <= '0;
            bcnt_q       <= 8'd0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            err_bunexp_q <= 1'b0;
        end else begin
            wq_wptr_q    <= wq_wptr_d;
            wq_rptr_q    <= wq_rptr_d;
            bcnt_q       <= bcnt_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            err_bunexp_q <= err_bunexp_d;
        end
    end

    // FIFO storage needs no reset; only pointer-covered entries are ever read.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            wq_tgt_q[wq_wptr_q[PtrW-1:0]] <= aw_tgtid;
            wq_len_q[wq_wptr_q[PtrW-1:0]] <= s_aw_len;
        end
    end

    assign err_bunexp = err_bunexp_q;

`ifdef RN_WLAST_CHECK_EN
    logic err_wlast_q;

    // Sticky flag when the master's last bit disagrees with the burst length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_wlast_q <= 1'b0;
        end else if (w_hs && (s_w_last != w_tail)) begin
            err_wlast_q <= 1'b1;
        end
    end

    assign err_wlast = err_wlast_q;
`else
    logic unused_w_last;
    assign unused_w_last = s_w_last;
    assign err_wlast     = 1'b0;
`endif

endmodule

// File: tb/tb_rn_axi_noc_bridge.sv
// Self-checking bench for rn_axi_noc_bridge: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based transaction model.
module tb_rn_axi_noc_bridge;

    localparam int ID_W = 11, ADDR_W = 32, DATA_W = 64, TGT_W = 2, TGT_LSB = 30;
    localparam int WQ_DEPTH = 4, MAX_WR = 8, MAX_RD = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic s_aw_valid, s_aw_ready; logic [ID_W-1:0] s_aw_id; logic [ADDR_W-1:0] s_aw_addr;
    logic [7:0] s_aw_len;
    logic s_w_valid, s_w_ready; logic [DATA_W-1:0] s_w_data; logic [DATA_W/8-1:0] s_w_strb;
    logic s_w_last;
    logic s_b_valid, s_b_ready; logic [ID_W-1:0] s_b_id; logic [1:0] s_b_resp;
    logic s_ar_valid, s_ar_ready; logic [ID_W-1:0] s_ar_id; logic [ADDR_W-1:0] s_ar_addr;
    logic [7:0] s_ar_len;
    logic s_r_valid, s_r_ready; logic [ID_W-1:0] s_r_id; logic [DATA_W-1:0] s_r_data;
    logic [1:0] s_r_resp; logic s_r_last;
    logic aw_valid, aw_ready; logic [ID_W+ADDR_W+7:0] aw_payload; logic [TGT_W-1:0] aw_tgtid;
    logic w_valid, w_ready, w_head, w_tail; logic [DATA_W+DATA_W/8-1:0] w_payload;
    logic [TGT_W-1:0] w_tgtid;
    logic b_valid, b_ready; logic [ID_W+1:0] b_payload;
    logic ar_valid, ar_ready; logic [ID_W+ADDR_W+7:0] ar_payload; logic [TGT_W-1:0] ar_tgtid;
    logic r_valid, r_ready, r_head, r_tail; logic [ID_W+DATA_W+1:0] r_payload;
    logic err_wlast, err_bunexp;

    rn_axi_noc_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id),
        .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
        .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
        .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
        .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_payload(aw_payload), .aw_tgtid(aw_tgtid),
        .w_valid(w_valid), .w_ready(w_ready), .w_head(w_head), .w_tail(w_tail),
        .w_payload(w_payload), .w_tgtid(w_tgtid),
        .b_valid(b_valid), .b_ready(b_ready), .b_payload(b_payload),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_payload(ar_payload), .ar_tgtid(ar_tgtid),
        .r_valid(r_valid), .r_ready(r_ready), .r_head(r_head), .r_tail(r_tail),
        .r_payload(r_payload),
        .err_wlast(err_wlast), .err_bunexp(err_bunexp)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: pending write bursts, beat within head burst, outstanding counts.
    logic [1:0] q_tgt[$];
    logic [7:0] q_len[$];
    int  beat, wr_out, rd_out;
    bit  e_wlast, e_bunexp;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_tail();
        return (q_len.size() != 0) && (beat == int'(q_len[0]));
    endfunction

    task automatic model_reset();
        q_tgt.delete(); q_len.delete();
        beat = 0; wr_out = 0; rd_out = 0; e_wlast = 0; e_bunexp = 0;
    endtask

    // Compare all outputs against the model, then advance model across one clock edge.
    task automatic cycle();
        bit ne, tail, aw_en, ar_en, aw_hs, w_hs, b_hs, ar_hs, rt_hs;
        #1;
        ne    = q_len.size() != 0;
        tail  = model_tail();
        aw_en = (q_len.size() < WQ_DEPTH) && (wr_out < MAX_WR);
        ar_en = rd_out < MAX_RD;
        if (!rst_n) begin
            check("rst_vr", 128'({aw_valid, s_aw_ready, w_valid, s_w_ready, s_b_valid, b_ready,
                                  ar_valid, s_ar_ready, s_r_valid, r_ready}), 128'(0));
        end else begin
            check("aw_vr", 128'({aw_valid, s_aw_ready}),
                  128'({s_aw_valid & aw_en, aw_ready & aw_en}));
            check("aw_tgt", 128'(aw_tgtid), 128'((s_aw_addr >> TGT_LSB) & 32'h3));
            check("aw_pl", 128'(aw_payload), 128'({s_aw_id, s_aw_addr, s_aw_len}));
            check("w_vr", 128'({w_valid, s_w_ready}), 128'({s_w_valid & ne, w_ready & ne}));
            if (ne) check("w_flit", 128'({w_tgtid, w_head, w_tail}),
                          128'({q_tgt[0], beat == 0, tail}));
            check("w_pl", 128'(w_payload), 128'({s_w_data, s_w_strb}));
            check("b_vr", 128'({s_b_valid, b_ready}), 128'({b_valid, s_b_ready}));
            check("b_fld", 128'({s_b_id, s_b_resp}), 128'(b_payload));
            check("ar_vr", 128'({ar_valid, s_ar_ready}),
                  128'({s_ar_valid & ar_en, ar_ready & ar_en}));
            check("ar_tgt", 128'(ar_tgtid), 128'((s_ar_addr >> TGT_LSB) & 32'h3));
            check("ar_pl", 128'(ar_payload), 128'({s_ar_id, s_ar_addr, s_ar_len}));
            check("r_vr", 128'({s_r_valid, r_ready}), 128'({r_valid, s_r_ready}));
            check("r_fld", 128'({s_r_id, s_r_data, s_r_resp, s_r_last}),
                  128'({r_payload, r_tail}));
            check("errs", 128'({err_wlast, err_bunexp}), 128'({e_wlast, e_bunexp}));
        end
        aw_hs = rst_n && s_aw_valid && aw_ready && aw_en;
        w_hs  = rst_n && s_w_valid && w_ready && ne;
        b_hs  = rst_n && b_valid && s_b_ready;
        ar_hs = rst_n && s_ar_valid && ar_ready && ar_en;
        rt_hs = rst_n && r_valid && s_r_ready && r_tail;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (w_hs) begin
`ifdef RN_WLAST_CHECK_EN
                if (s_w_last != tail) e_wlast = 1;
`endif
                if (tail) begin
                    void'(q_tgt.pop_front()); void'(q_len.pop_front()); beat = 0;
                end else begin
                    beat++;
                end
            end
            if (aw_hs) begin
                q_tgt.push_back(2'((s_aw_addr >> TGT_LSB) & 32'h3));
                q_len.push_back(s_aw_len);
            end
            if (b_hs && wr_out == 0) e_bunexp = 1;
            if (aw_hs && !b_hs) wr_out++;
            else if (b_hs && !aw_hs && wr_out > 0) wr_out--;
            if (ar_hs && !rt_hs) rd_out++;
            else if (rt_hs && !ar_hs && rd_out > 0) rd_out--;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        s_aw_valid = 0; s_aw_id = '0; s_aw_addr = '0; s_aw_len = '0; aw_ready = 1;
        s_w_valid = 0; s_w_data = '0; s_w_strb = '0; s_w_last = 0; w_ready = 1;
        b_valid = 0; b_payload = '0; s_b_ready = 1;
        s_ar_valid = 0; s_ar_id = '0; s_ar_addr = '0; s_ar_len = '0; ar_ready = 1;
        r_valid = 0; r_head = 0; r_tail = 0; r_payload = '0; s_r_ready = 1;
    endtask

    initial begin
        logic [95:0] wide;
        model_reset();
        idle();
        rst_n = 0;
        cycle(); cycle();
        rst_n = 1;

        // Single len=3 burst to target 1.
        s_aw_valid = 1; s_aw_addr = 32'h4000_0000; s_aw_len = 8'd3; s_aw_id = 11'h5;
        s_w_valid = 1; s_w_last = model_tail(); cycle();
        s_aw_valid = 0;
        repeat (5) begin
            s_w_data = {$urandom, $urandom}; s_w_strb = 8'($urandom);
            s_w_last = model_tail(); cycle();
        end

        // Five len=0 AWs with W held off: fifth stalls until a pop.
        s_w_valid = 0; s_aw_valid = 1; s_aw_len = 8'd0;
        repeat (5) begin s_aw_addr = $urandom; cycle(); end
        s_w_valid = 1; s_w_last = model_tail(); cycle();
        s_w_valid = 0; cycle();

        // Fill to MAX_WR outstanding, stall, release one with B.
        s_w_valid = 1;
        repeat (10) begin s_aw_addr = $urandom; s_w_last = model_tail(); cycle(); end
        b_valid = 1; b_payload = 13'($urandom); s_w_last = model_tail(); cycle();
        b_valid = 0; s_w_last = model_tail(); cycle();
        s_aw_valid = 0;
        repeat (14) begin
            b_valid = (wr_out > 0); b_payload = 13'($urandom);
            s_w_last = model_tail(); cycle();
        end

        // Unexpected B, then a len=1 read.
        b_valid = 1; b_payload = 13'($urandom); cycle();
        b_valid = 0; cycle();
        s_ar_valid = 1; s_ar_len = 8'd1; s_ar_addr = 32'hC000_0010; s_ar_id = 11'h33; cycle();
        s_ar_valid = 0; r_valid = 1; r_head = 1; r_tail = 0;
        wide = {$urandom, $urandom, $urandom}; r_payload = wide[76:0]; cycle();
        r_head = 0; r_tail = 1; cycle();
        r_valid = 0; r_tail = 0; cycle();

        // len=1 burst with a premature last on beat 0.
        s_w_valid = 0; s_aw_valid = 1; s_aw_len = 8'd1; s_aw_addr = 32'h8000_0000; cycle();
        s_aw_valid = 0; s_w_valid = 1; s_w_last = 1; cycle();
        s_w_last = 1; cycle();
        s_w_valid = 0; s_w_last = 0; cycle();

        // Reset in the middle of a len=3 burst, then a fresh burst.
        s_aw_valid = 1; s_aw_len = 8'd3; cycle();
        s_aw_valid = 0; s_w_valid = 1;
        repeat (2) begin s_w_last = model_tail(); cycle(); end
        rst_n = 0; cycle();
        rst_n = 1; s_w_valid = 0; s_aw_valid = 1; s_aw_len = 8'd1; s_aw_addr = 32'h4000_0100;
        cycle();
        s_aw_valid = 0; s_w_valid = 1;
        repeat (3) begin s_w_last = model_tail(); cycle(); end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            s_aw_valid = 1'($urandom); aw_ready = ($urandom_range(0, 3) != 0);
            s_aw_id    = 11'($urandom); s_aw_addr = $urandom; s_aw_len = 8'($urandom_range(0, 3));
            s_w_valid  = 1'($urandom); w_ready = ($urandom_range(0, 3) != 0);
            s_w_data   = {$urandom, $urandom}; s_w_strb = 8'($urandom);
            s_w_last   = model_tail() ^ ($urandom_range(0, 7) == 0);
            b_valid    = (wr_out > 0) && ($urandom_range(0, 1) == 1);
            s_b_ready  = 1'($urandom); b_payload = 13'($urandom);
            s_ar_valid = 1'($urandom); ar_ready = ($urandom_range(0, 3) != 0);
            s_ar_id    = 11'($urandom); s_ar_addr = $urandom; s_ar_len = 8'($urandom);
            r_valid    = 1'($urandom); s_r_ready = 1'($urandom);
            r_head     = 1'($urandom); r_tail = ($urandom_range(0, 2) == 0);
            wide       = {$urandom, $urandom, $urandom}; r_payload = wide[76:0];
            cycle();
        end

        idle();
        rst_n = 1;
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
